renode_input_event_encoder: RTL and testbench

//  Converts level changes on DUT-driven GPIO lines into discrete (line number, value) events for Renode.
//  It is the reverse path of Renode's interrupt-to-output handling: it detects edges, coalesces them,

---
 rtl/renode_input_event_encoder_if.sv | 27 ++
 rtl/renode_input_event_encoder.sv | 117 +++++++++++
 tb/tb_renode_input_event_encoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/renode_input_event_encoder_if.sv
// Event handshake between the input event encoder and the Renode message sender.
//   event_valid  : queue head holds an event
//   event_ready  : sender accepts the head this cycle
//   event_number : line index of the head event
//   event_value  : line level of the head event
interface renode_input_event_encoder_if #(
  parameter int NumWidth = 1
);
  logic                event_valid;
  logic                event_ready;
  logic [NumWidth-1:0] event_number;
  logic                event_value;

  modport master (
    output event_valid,
    output event_number,
    output event_value,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_number,
    input  event_value,
    output event_ready
  );
endinterface

// File: rtl/renode_input_event_encoder.sv
// Converts level changes on GPIO lines into (line number, value) events for Renode.
// Changes are latched per line as pending, merged while unsent, enqueued one per
// cycle in fixed priority (lowest index first) and handed out over valid/ready.
//   clk            : clock, all state updates on posedge
//   rst            : synchronous active-high reset
//   inputs         : monitored lines, already synchronous to clk
//   evt            : event handshake (master side)
//   fifo_level     : entries currently queued
//   coalesce_count : saturating count of changes merged into an unsent pending event
module renode_input_event_encoder #(
  parameter int InputsCount = 1,
  parameter int FifoDepth   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [InputsCount-1:0]       inputs,
  renode_input_event_encoder_if.master evt,
  output logic [$clog2(FifoDepth):0]   fifo_level,
  output logic [15:0]                  coalesce_count
);

  localparam int NumWidth = (InputsCount > 1) ? $clog2(InputsCount) : 1;
  localparam int PtrW     = $clog2(FifoDepth);
  localparam int LvlW     = PtrW + 1;

  typedef struct packed {
    logic [NumWidth-1:0] number;
    logic                value;
  } event_t;

  logic [InputsCount-1:0] prev;
  logic [InputsCount-1:0] pending;
  logic [InputsCount-1:0] latest;
  event_t                 mem [FifoDepth];
  logic [PtrW-1:0]        rd_ptr;
  logic [PtrW-1:0]        wr_ptr;

  logic [InputsCount-1:0] chg;
  logic [InputsCount-1:0] pending_n;
  logic [InputsCount-1:0] latest_n;
  logic [NumWidth-1:0]    sel;
  logic                   sel_value;
  logic                   any_pending;
  logic                   valid;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [16:0]            coal_n;
  logic [16:0]            coal_sum;

  always_comb begin
    chg         = inputs ^ prev;
    any_pending = |pending;
    valid       = (fifo_level != '0);
    full        = (fifo_level == LvlW'(FifoDepth));
    pop         = valid & evt.event_ready;
    push        = any_pending & (~full | pop);

    // Lowest pending index wins; scanning downwards leaves the lowest in sel.
    sel       = '0;
    sel_value = 1'b0;
    for (int unsigned i = InputsCount; i > 0; i--) begin
      if (pending[i-1]) begin
        sel       = NumWidth'(i - 1);
        sel_value = latest[i-1];
      end
    end

    // The enqueued line is cleared first, so a change on the same edge re-arms it
    // with the new level while the old level goes into the queue.
    pending_n = pending;
    coal_n    = '0;
    for (int unsigned i = 0; i < InputsCount; i++) begin
      if (push && sel == NumWidth'(i)) begin
        pending_n[i] = 1'b0;
      end else if (chg[i] && pending[i]) begin
        coal_n = coal_n + 17'd1;
      end
    end
    pending_n = pending_n | chg;
    latest_n  = (latest & ~chg) | (inputs & chg);
    coal_sum  = {1'b0, coalesce_count} + coal_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev           <= inputs;
      pending        <= '0;
      latest         <= inputs;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_level     <= '0;
      coalesce_count <= '0;
    end else begin
      prev    <= inputs;
      pending <= pending_n;
      latest  <= latest_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level     <= fifo_level + LvlW'(push) - LvlW'(pop);
      coalesce_count <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= '{number: sel, value: sel_value};
    end
  end

  always_comb begin
    evt.event_valid  = valid;
    evt.event_number = valid ? mem[rd_ptr].number : '0;
    evt.event_value  = valid ? mem[rd_ptr].value  : 1'b0;
  end

endmodule

// File: tb/tb_renode_input_event_encoder.sv
module tb_renode_input_event_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  inputs;
  logic [3:0]  fifo_level;
  logic [15:0] coalesce_count;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  renode_input_event_encoder_if #(.NumWidth(2)) evt_if ();

  renode_input_event_encoder #(
    .InputsCount(4),
    .FifoDepth  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inputs        (inputs),
    .evt           (evt_if),
    .fifo_level    (fifo_level),
    .coalesce_count(coalesce_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_valid"}, 32'(evt_if.event_valid), 32'd0);
    check_eq({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  task automatic check_head(input string tag, input int num, input int val);
    check_eq({tag, "_valid"}, 32'(evt_if.event_valid), 32'd1);
    check_eq({tag, "_num"},   32'(evt_if.event_number), 32'(num));
    check_eq({tag, "_val"},   32'(evt_if.event_value), 32'(val));
  endtask

  int drain_num [9] = '{1, 2, 3, 0, 1, 2, 3, 1, 0};
  int drain_val [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};

  initial begin
    // Reset held with lines at 1010: no events, no spurious events after release.
    rst = 1'b1;
    inputs = 4'b1010;
    evt_if.event_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_empty("rst_hold");
    end
    check_eq("rst_coal", 32'(coalesce_count), 32'd0);
    check_eq("rst_num",  32'(evt_if.event_number), 32'd0);
    check_eq("rst_val",  32'(evt_if.event_value), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_empty("post_rst");
    end

    // Restart from all-low lines.
    rst = 1'b1;
    inputs = 4'b0000;
    step();
    rst = 1'b0;
    evt_if.event_ready = 1'b1;
    step();
    step();

    // Single change on line 2: head appears after two edges, one event only.
    inputs = 4'b0100;
    step();
    check_eq("single_e0", 32'(evt_if.event_valid), 32'd0);
    step();
    check_head("single_e1", 2, 1);
    step();
    check_empty("single_e2");

    inputs = 4'b0000;
    step();
    step();
    check_head("fall2", 2, 0);
    step();
    check_empty("fall2_done");

    // All four lines rise together: events 0..3 on consecutive cycles.
    inputs = 4'b1111;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check_head($sformatf("all_rise%0d", k), k, 1);
    end
    step();
    check_empty("all_rise_done");

    // Fill the queue by changing lines 0..3 in turn with the sender stalled.
    evt_if.event_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      inputs[k % 4] = ~inputs[k % 4];
      step();
    end
    step();
    check_eq("fill_level", 32'(fifo_level), 32'd8);
    check_eq("fill_coal",  32'(coalesce_count), 32'd0);

    // Line 1 pending while full; one ready cycle pushes and pops on the same edge.
    inputs[1] = 1'b0;
    step();
    check_eq("full_hold_level", 32'(fifo_level), 32'd8);
    check_head("full_hold", 0, 0);
    evt_if.event_ready = 1'b1;
    step();
    evt_if.event_ready = 1'b0;
    check_eq("pushpop_level", 32'(fifo_level), 32'd8);
    check_head("pushpop_head", 1, 0);
    step();
    check_eq("pushpop_after", 32'(fifo_level), 32'd8);

    // Toggle line 0 nine times while full: one pending event, eight merges.
    for (int k = 0; k < 9; k++) begin
      inputs[0] = ~inputs[0];
      step();
    end
    check_eq("coal_level", 32'(fifo_level), 32'd8);
    check_eq("coal_count", 32'(coalesce_count), 32'd8);

    // Drain: queued events in order, then the coalesced line 0 with its final level.
    evt_if.event_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      check_head($sformatf("drain%0d", j), drain_num[j], drain_val[j]);
      step();
    end
    check_empty("drain_done");
    check_eq("drain_coal", 32'(coalesce_count), 32'd8);

    // Five queued and two pending, then reset discards everything.
    evt_if.event_ready = 1'b0;
    inputs[0] = ~inputs[0]; step();
    inputs[1] = ~inputs[1]; step();
    inputs[2] = ~inputs[2]; step();
    inputs[3] = ~inputs[3]; step();
    inputs[2:0] = ~inputs[2:0];
    step();
    step();
    check_eq("pre_rst_level", 32'(fifo_level), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_empty("mid_rst");
    check_eq("mid_rst_coal", 32'(coalesce_count), 32'd0);
    check_eq("mid_rst_num",  32'(evt_if.event_number), 32'd0);
    check_eq("mid_rst_val",  32'(evt_if.event_value), 32'd0);
    evt_if.event_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_empty("after_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
